// File: rtl/bus_mem_responder.sv
// Word-organised on-chip RAM responder for the core memory bus.
// Requests are accepted from IDLE, optionally delayed, and answered with a one-cycle ready/fault strobe.
module bus_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WAIT_STATES = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic        i_clk,
   input  logic        i_nreset,
   input  logic        i_memread,
   input  logic        i_memwrite,
   input  logic [31:0] i_memaddr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_fault
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WS   = 4'(WAIT_STATES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          write_q, fault_q;
   logic          ready_q, resp_fault_q;
   logic [31:0]   rdata_q;

   logic [31:0]   off;
   logic          in_range, in_fault, req;
   logic [AW-1:0] in_idx;

   logic [AW-1:0] cur_idx;
   logic [31:0]   cur_wdata;
   logic [3:0]    cur_wstrb;
   logic          cur_write, cur_fault;
   logic          go_resp, mem_we;
   logic [7:0]    lane_rd [4];

   // Offset from the RAM base; wraps so addresses below the base land out of range.
   assign off      = i_memaddr - BASE_ADDR;
   assign in_range = {1'b0, off} < SPAN;
   assign in_idx   = off[AW+1:2];
   assign req      = i_memread | i_memwrite;
   assign in_fault = !in_range || (i_memread && i_memwrite) || (i_memwrite && (i_wstrb == 4'd0));

   // With no wait states the response edge is the accept edge, so the live bus is used directly.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_idx   = in_idx;
         cur_wdata = i_wdata;
         cur_wstrb = i_wstrb;
         cur_write = i_memwrite;
         cur_fault = in_fault;
      end else begin
         cur_idx   = idx_q;
         cur_wdata = wdata_q;
         cur_wstrb = wstrb_q;
         cur_write = write_q;
         cur_fault = fault_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      go_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (WS == 4'd0) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
               go_resp = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Gating with the reset keeps a store from landing while reset is held.
   assign mem_we = go_resp && cur_write && !cur_fault && i_nreset;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];

         always_ff @(posedge i_clk) begin
            if (mem_we && cur_wstrb[gi]) begin
               lane_mem[cur_idx] <= cur_wdata[8*gi +: 8];
            end
         end

         assign lane_rd[gi] = lane_mem[cur_idx];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         write_q      <= 1'b0;
         fault_q      <= 1'b0;
         ready_q      <= 1'b0;
         resp_fault_q <= 1'b0;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= go_resp;
         resp_fault_q <= go_resp && cur_fault;
         if (go_resp) begin
            rdata_q <= (cur_write || cur_fault) ? 32'd0
                       : {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
         end
         if ((state_q == ST_IDLE) && req) begin
            idx_q   <= in_idx;
            wdata_q <= i_wdata;
            wstrb_q <= i_wstrb;
            write_q <= i_memwrite;
            fault_q <= in_fault;
         end
      end
   end

   assign o_rdata = rdata_q;
   assign o_ready = ready_q;
   assign o_fault = resp_fault_q;

endmodule
